metronome_core: RTL and testbench

- Timing engine directly downstream of the metronome AXI4-Lite register slave; consumes its four config registers (ctrl, bpm, beats-per-bar, accent) as level inputs.
- Converts BPM to a beat period in clock cycles with an iterative restoring divider, then generates beat and bar strobes, a beat index and click/accent drive.
- `period_out`, `beat_idx` and `busy` feed back to the register slave for readback.

---
 rtl/metronome_core.sv | 232 +++++++++++++++++++++++
 tb/tb_metronome_core.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/metronome_core.sv
// Metronome timing engine: clamps the requested BPM, divides one minute of clock cycles by it
// with an iterative restoring divider, then sequences beat/bar strobes, beat index and the
// click/accent drive from the resulting period.
`timescale 1ns / 1ps

module metronome_core #(
  parameter longint unsigned CLK_FREQ_HZ  = 100000000,
  parameter int unsigned     BPM_MIN      = 20,
  parameter int unsigned     BPM_MAX      = 300,
  parameter int unsigned     CLICK_CYCLES = 5000000,
  parameter int unsigned     DIV_W        = $clog2(64'd60 * CLK_FREQ_HZ + 64'd1)
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        cfg_enable,
  input  logic [8:0]  cfg_bpm,
  input  logic [3:0]  cfg_beats_per_bar,
  input  logic        cfg_accent_en,
  output logic        beat_pulse,
  output logic        bar_pulse,
  output logic [3:0]  beat_idx,
  output logic        click,
  output logic        accent,
  output logic        busy,
  output logic [31:0] period_out
);

  localparam longint unsigned MINUTE    = 64'd60 * CLK_FREQ_HZ;
  localparam logic [DIV_W-1:0] MINUTE_W = DIV_W'(MINUTE);
  localparam logic [8:0]      BPM_LO    = 9'(BPM_MIN);
  localparam logic [8:0]      BPM_HI    = 9'(BPM_MAX);
  localparam int unsigned     STEP_W    = $clog2(DIV_W + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIV_W - 1);
  localparam int unsigned     CLK_CNT_W = $clog2(CLICK_CYCLES + 2);
  localparam logic [CLK_CNT_W-1:0] CLICK_LOAD = CLK_CNT_W'(CLICK_CYCLES);

  typedef enum logic [0:0] {DIdle, DBusy} div_state_t;
  typedef enum logic [1:0] {SIdle, SWait, SRun} seq_state_t;

  // Divider state
  div_state_t         div_state_q, div_state_d;
  logic [8:0]         bpm_q, bpm_d;
  logic [DIV_W-1:0]   dvd_q, dvd_d;
  logic [8:0]         rem_q, rem_d;
  logic [DIV_W-1:0]   quo_q, quo_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [31:0]        period_q, period_d;

  // Sequencer state
  seq_state_t         seq_q, seq_d;
  logic [31:0]        per_cnt_q, per_cnt_d;
  logic [CLK_CNT_W-1:0] click_cnt_q, click_cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic               acc_flag_q, acc_flag_d;
  logic               beat_q, beat_d;
  logic               bar_q, bar_d;
  logic               click_q, click_d;
  logic               accent_q, accent_d;

  logic [8:0]         bpm_c;
  logic               div_start;
  logic [9:0]         rem_sh;
  logic [9:0]         rem_sub;
  logic               rem_ge;
  logic [DIV_W-1:0]   quo_nx;
  logic [3:0]         bpb_eff;
  logic [4:0]         idx_inc;
  logic [3:0]         idx_nx;
  logic               beat_now;

  // Clamp BPM and step the restoring divider one quotient bit per cycle
  always_comb begin
    bpm_c = cfg_bpm;
    if (cfg_bpm < BPM_LO) begin
      bpm_c = BPM_LO;
    end else if (cfg_bpm > BPM_HI) begin
      bpm_c = BPM_HI;
    end
    div_start = cfg_enable && ((bpm_c != bpm_q) || (period_q == '0));

    rem_sh  = {rem_q, dvd_q[DIV_W-1]};
    rem_ge  = (rem_sh >= {1'b0, bpm_q});
    rem_sub = rem_sh - {1'b0, bpm_q};
    quo_nx  = DIV_W'({quo_q, rem_ge});

    div_state_d = div_state_q;
    bpm_d       = bpm_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    step_d      = step_q;
    period_d    = period_q;

    unique case (div_state_q)
      DIdle: begin
        if (div_start) begin
          div_state_d = DBusy;
          bpm_d       = bpm_c;
          dvd_d       = MINUTE_W;
          rem_d       = '0;
          quo_d       = '0;
          step_d      = '0;
        end
      end
      DBusy: begin
        if (!cfg_enable) begin
          // Abort; period_out keeps the last completed result
          div_state_d = DIdle;
        end else begin
          dvd_d  = dvd_q << 1;
          rem_d  = rem_ge ? 9'(rem_sub) : 9'(rem_sh);
          quo_d  = quo_nx;
          step_d = step_q + STEP_W'(1);
          if (step_q == LAST_STEP) begin
            div_state_d = DIdle;
            period_d    = 32'(quo_nx);
          end
        end
      end
      default: div_state_d = DIdle;
    endcase
  end

  // Beat sequencer: waits for a valid period, then counts beats, bar index and click time
  always_comb begin
    bpb_eff = (cfg_beats_per_bar == 4'd0) ? 4'd1 : cfg_beats_per_bar;
    idx_inc = {1'b0, idx_q} + 5'd1;
    idx_nx  = (idx_inc >= {1'b0, bpb_eff}) ? 4'd0 : 4'(idx_inc);

    beat_now    = 1'b0;
    seq_d       = seq_q;
    per_cnt_d   = per_cnt_q;
    idx_d       = idx_q;
    acc_flag_d  = acc_flag_q;
    click_cnt_d = click_cnt_q;

    unique case (seq_q)
      SIdle: begin
        if (cfg_enable) seq_d = SWait;
      end
      SWait: begin
        // Go once no division is running or pending and a period exists
        if ((div_state_q == DIdle) && !div_start && (period_q != '0)) begin
          seq_d    = SRun;
          beat_now = 1'b1;
        end
      end
      SRun: begin
        if (per_cnt_q == '0) begin
          beat_now = 1'b1;
        end else begin
          per_cnt_d = per_cnt_q - 32'd1;
        end
      end
      default: seq_d = SIdle;
    endcase

    if (beat_now) begin
      // Reload from the current period so a new period only applies to the next interval
      per_cnt_d   = period_q - 32'd1;
      idx_d       = (seq_q == SWait) ? 4'd0 : idx_nx;
      acc_flag_d  = (idx_d == 4'd0) && cfg_accent_en;
      click_cnt_d = CLICK_LOAD;
    end else if (click_cnt_q != '0) begin
      click_cnt_d = click_cnt_q - CLK_CNT_W'(1);
    end

    beat_d = beat_now;
    bar_d  = beat_now && (idx_d == 4'd0);

    if (!cfg_enable) begin
      seq_d       = SIdle;
      per_cnt_d   = '0;
      idx_d       = 4'd0;
      acc_flag_d  = 1'b0;
      click_cnt_d = '0;
      beat_d      = 1'b0;
      bar_d       = 1'b0;
    end

    click_d  = (click_cnt_d != '0);
    accent_d = acc_flag_d && click_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      div_state_q <= DIdle;
      bpm_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      step_q      <= '0;
      period_q    <= '0;
      seq_q       <= SIdle;
      per_cnt_q   <= '0;
      click_cnt_q <= '0;
      idx_q       <= '0;
      acc_flag_q  <= 1'b0;
      beat_q      <= 1'b0;
      bar_q       <= 1'b0;
      click_q     <= 1'b0;
      accent_q    <= 1'b0;
    end else begin
      div_state_q <= div_state_d;
      bpm_q       <= bpm_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      step_q      <= step_d;
      period_q    <= period_d;
      seq_q       <= seq_d;
      per_cnt_q   <= per_cnt_d;
      click_cnt_q <= click_cnt_d;
      idx_q       <= idx_d;
      acc_flag_q  <= acc_flag_d;
      beat_q      <= beat_d;
      bar_q       <= bar_d;
      click_q     <= click_d;
      accent_q    <= accent_d;
    end
  end

  assign beat_pulse = beat_q;
  assign bar_pulse  = bar_q;
  assign beat_idx   = idx_q;
  assign click      = click_q;
  assign accent     = accent_q;
  assign busy       = (div_state_q == DBusy);
  assign period_out = period_q;

endmodule

// File: tb/tb_metronome_core.sv
// Self-checking bench for metronome_core: randomized configurations checked against a
// beat-level model (period = minute / clamped BPM, index = beat number mod bar length).
`timescale 1ns / 1ps

module tb_metronome_core;

  localparam int FREQ   = 100;  // minute = 6000 cycles
  localparam int DIVW   = 13;
  localparam int FREQ2  = 10;   // minute = 600 cycles
  localparam int DIVW2  = 10;
  localparam int CLICK  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, acc;
  logic [8:0]  bpm;
  logic [3:0]  bpb;
  logic        beat_pulse, bar_pulse, click, accent, busy;
  logic [3:0]  beat_idx;
  logic [31:0] period_out;

  logic        rst2, en2, acc2;
  logic [8:0]  bpm2;
  logic [3:0]  bpb2;
  logic        beat2, bar2, click2, accent2, busy2;
  logic [3:0]  idx2;
  logic [31:0] period2;

  int n_checks = 0;
  int n_pass   = 0;

  metronome_core #(.CLK_FREQ_HZ(FREQ), .CLICK_CYCLES(CLICK)) dut (
    .ACLK(clk), .ARESET(rst), .cfg_enable(en), .cfg_bpm(bpm), .cfg_beats_per_bar(bpb),
    .cfg_accent_en(acc), .beat_pulse(beat_pulse), .bar_pulse(bar_pulse), .beat_idx(beat_idx),
    .click(click), .accent(accent), .busy(busy), .period_out(period_out)
  );

  metronome_core #(.CLK_FREQ_HZ(FREQ2), .CLICK_CYCLES(CLICK)) dut_fast (
    .ACLK(clk), .ARESET(rst2), .cfg_enable(en2), .cfg_bpm(bpm2), .cfg_beats_per_bar(bpb2),
    .cfg_accent_en(acc2), .beat_pulse(beat2), .bar_pulse(bar2), .beat_idx(idx2),
    .click(click2), .accent(accent2), .busy(busy2), .period_out(period2)
  );

  function automatic int clamp_bpm(input int b);
    if (b < 20) return 20;
    if (b > 300) return 300;
    return b;
  endfunction

  function automatic int ref_period(input int freq, input int b);
    return (60 * freq) / clamp_bpm(b);
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next beat; tallies click/accent/busy on the cycles in between
  task automatic wait_beat(input int limit, output int cycles, output int nclick,
                           output int nacc, output int nbusy);
    bit done;
    done = 1'b0;
    cycles = 0; nclick = 0; nacc = 0; nbusy = 0;
    while (!done) begin
      @(negedge clk);
      cycles++;
      if (beat_pulse) begin
        done = 1'b1;
      end else begin
        if (click) nclick++;
        if (accent) nacc++;
        if (busy) nbusy++;
        if (cycles >= limit) begin
          cycles = -1;
          done = 1'b1;
        end
      end
    end
  endtask

  // Reset mid-run, then enable with a fresh config and check divide latency and period
  task automatic start_fresh(input int b, input int pb, input bit a);
    int cyc, nc, na, nb;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({beat_pulse, bar_pulse, beat_idx, click, accent, busy, period_out} !== '0)
      $display("FAIL reset_state: got %b/%0d want all zero",
               {beat_pulse, bar_pulse, beat_idx, click, accent, busy}, period_out);
    else n_pass++;
    rst = 1'b0;
    bpm = 9'(b);
    bpb = 4'(pb);
    acc = a;
    en  = 1'b1;
    wait_beat(DIVW + 20, cyc, nc, na, nb);
    n_checks++;
    if (cyc !== DIVW + 2)
      $display("FAIL first_beat_latency bpm=%0d: got %0d want %0d", b, cyc, DIVW + 2);
    else n_pass++;
    n_checks++;
    if (nb !== DIVW) $display("FAIL busy_cycles bpm=%0d: got %0d want %0d", b, nb, DIVW);
    else n_pass++;
    n_checks++;
    if (period_out !== 32'(ref_period(FREQ, b)))
      $display("FAIL period bpm=%0d: got %0d want %0d", b, period_out, ref_period(FREQ, b));
    else n_pass++;
  endtask

  // Check n further beats against the model; entry point is a beat numbered bn
  task automatic observe_beats(input int n, input int p, input int pb, input bit a,
                               inout int bn);
    int eff, prev, c0, a0, cyc, nc, na, nb, want_c, want_a;
    eff = (pb == 0) ? 1 : pb;
    n_checks++;
    if (beat_idx !== 4'(bn % eff))
      $display("FAIL beat_idx beat=%0d: got %0d want %0d", bn, beat_idx, bn % eff);
    else n_pass++;
    n_checks++;
    if (bar_pulse !== ((bn % eff) == 0))
      $display("FAIL bar_pulse beat=%0d: got %b want %b", bn, bar_pulse, (bn % eff) == 0);
    else n_pass++;
    for (int k = 0; k < n; k++) begin
      prev = bn % eff;
      c0 = click ? 1 : 0;
      a0 = accent ? 1 : 0;
      wait_beat(p + 20, cyc, nc, na, nb);
      bn++;
      want_c = min_int(CLICK, p);
      want_a = (prev == 0 && a) ? want_c : 0;
      n_checks++;
      if (cyc !== p) $display("FAIL interval beat=%0d: got %0d want %0d", bn, cyc, p);
      else n_pass++;
      n_checks++;
      if (c0 + nc !== want_c)
        $display("FAIL click_len beat=%0d: got %0d want %0d", bn, c0 + nc, want_c);
      else n_pass++;
      n_checks++;
      if (a0 + na !== want_a)
        $display("FAIL accent_len beat=%0d: got %0d want %0d", bn, a0 + na, want_a);
      else n_pass++;
      n_checks++;
      if (beat_idx !== 4'(bn % eff))
        $display("FAIL beat_idx beat=%0d: got %0d want %0d", bn, beat_idx, bn % eff);
      else n_pass++;
      n_checks++;
      if (bar_pulse !== ((bn % eff) == 0))
        $display("FAIL bar_pulse beat=%0d: got %b want %b", bn, bar_pulse, (bn % eff) == 0);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({beat_pulse, bar_pulse, beat_idx, click, accent, busy, period_out} !== '0)
      $display("FAIL reset_outputs: got %b/%0d want all zero",
               {beat_pulse, bar_pulse, beat_idx, click, accent, busy}, period_out);
    else n_pass++;
    n_checks++;
    if ({beat2, bar2, idx2, click2, accent2, busy2, period2} !== '0)
      $display("FAIL reset_outputs_fast: got %b/%0d want all zero",
               {beat2, bar2, idx2, click2, accent2, busy2}, period2);
    else n_pass++;
  endtask

  task automatic test_start();
    int bn;
    start_fresh(60, 4, 1'b0);
    bn = 0;
    observe_beats(4, 100, 4, 1'b0, bn);
  endtask

  task automatic test_clamp();
    int vals[3] = '{7, 0, 400};
    int bn, b, pb;
    bit a;
    for (int i = 0; i < 3; i++) begin
      start_fresh(vals[i], 4, 1'b0);
      bn = 0;
      observe_beats(1, ref_period(FREQ, vals[i]), 4, 1'b0, bn);
    end
    repeat (4) begin
      b  = $urandom_range(0, 511);
      pb = $urandom_range(0, 15);
      a  = 1'($urandom_range(0, 1));
      start_fresh(b, pb, a);
      bn = 0;
      observe_beats(3, ref_period(FREQ, b), pb, a, bn);
    end
  endtask

  task automatic test_accent_click();
    int bn, b;
    b = $urandom_range(100, 250);
    start_fresh(b, 3, 1'b1);
    bn = 0;
    observe_beats(4, ref_period(FREQ, b), 3, 1'b1, bn);
    start_fresh(300, 3, 1'b1);
    bn = 0;
    observe_beats(4, 20, 3, 1'b1, bn);
  endtask

  task automatic test_bpb_edges();
    int bn, cyc, nc, na, nb;
    start_fresh(300, 0, 1'b1);
    bn = 0;
    observe_beats(3, 20, 0, 1'b1, bn);
    start_fresh(300, 8, 1'b0);
    bn = 0;
    observe_beats(5, 20, 8, 1'b0, bn);
    bpb = 4'd2;
    wait_beat(40, cyc, nc, na, nb);
    n_checks++;
    if (cyc !== 20) $display("FAIL bpb_lower_interval: got %0d want 20", cyc);
    else n_pass++;
    n_checks++;
    if (beat_idx !== 4'd0) $display("FAIL bpb_lower_idx: got %0d want 0", beat_idx);
    else n_pass++;
    n_checks++;
    if (bar_pulse !== 1'b1) $display("FAIL bpb_lower_bar: got %b want 1", bar_pulse);
    else n_pass++;
  endtask

  task automatic test_live_change();
    int bn, cyc, nc, na, nb;
    start_fresh(60, 4, 1'b0);
    bn = 0;
    observe_beats(1, 100, 4, 1'b0, bn);
    tick(30);
    bpm = 9'd120;
    wait_beat(200, cyc, nc, na, nb);
    bn++;
    n_checks++;
    if (cyc !== 70) $display("FAIL live_inflight_interval: got %0d want 70", cyc);
    else n_pass++;
    n_checks++;
    if (nb !== DIVW) $display("FAIL live_busy_cycles: got %0d want %0d", nb, DIVW);
    else n_pass++;
    n_checks++;
    if (period_out !== 32'd50) $display("FAIL live_period: got %0d want 50", period_out);
    else n_pass++;
    observe_beats(3, 50, 4, 1'b0, bn);
  endtask

  task automatic test_disable();
    int cyc, nc, na, nb, beats, busies, bn;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bpm = 9'd90;
    bpb = 4'd4;
    acc = 1'b0;
    en  = 1'b1;
    tick(5);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL disable_busy_before: got %b want 1", busy);
    else n_pass++;
    en = 1'b0;
    tick(1);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL disable_busy_after: got %b want 0", busy);
    else n_pass++;
    beats = 0;
    busies = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (beat_pulse) beats++;
      if (busy) busies++;
    end
    n_checks++;
    if (beats + busies !== 0)
      $display("FAIL disable_quiet: got beats=%0d busy=%0d want 0/0", beats, busies);
    else n_pass++;

    start_fresh(150, 4, 1'b1);
    bn = 0;
    observe_beats(1, 40, 4, 1'b1, bn);
    tick(7);
    en = 1'b0;
    tick(1);
    n_checks++;
    if ({beat_pulse, bar_pulse, beat_idx, click, accent, busy} !== '0)
      $display("FAIL disable_outputs: got %b want 0",
               {beat_pulse, bar_pulse, beat_idx, click, accent, busy});
    else n_pass++;
    n_checks++;
    if (period_out !== 32'd40) $display("FAIL disable_period_kept: got %0d want 40", period_out);
    else n_pass++;
    tick(5);
    en = 1'b1;
    wait_beat(10, cyc, nc, na, nb);
    n_checks++;
    if (cyc !== 2) $display("FAIL reenable_latency: got %0d want 2", cyc);
    else n_pass++;
    n_checks++;
    if (nb !== 0) $display("FAIL reenable_no_divide: got %0d busy cycles want 0", nb);
    else n_pass++;
    n_checks++;
    if ({beat_idx, bar_pulse, click, accent} !== {4'd0, 1'b1, 1'b1, 1'b1})
      $display("FAIL reenable_first_beat: got %b want 0000111",
               {beat_idx, bar_pulse, click, accent});
    else n_pass++;
  endtask

  // Period shorter than the click length: click never drops
  task automatic test_fast_click();
    int cyc, clicks, beats;
    bit seen;
    @(negedge clk);
    rst2 = 1'b1;
    bpm2 = 9'd300;
    bpb2 = 4'd1;
    acc2 = 1'b0;
    en2  = 1'b0;
    @(negedge clk);
    rst2 = 1'b0;
    en2  = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (beat2) seen = 1'b1;
    end
    n_checks++;
    if (!seen || cyc !== DIVW2 + 2)
      $display("FAIL fast_first_beat: got %0d seen=%b want %0d", cyc, seen, DIVW2 + 2);
    else n_pass++;
    n_checks++;
    if (period2 !== 32'(ref_period(FREQ2, 300)))
      $display("FAIL fast_period: got %0d want %0d", period2, ref_period(FREQ2, 300));
    else n_pass++;
    clicks = 0;
    beats  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (click2) clicks++;
      if (beat2) beats++;
    end
    n_checks++;
    if (clicks !== 40) $display("FAIL fast_click_continuous: got %0d want 40", clicks);
    else n_pass++;
    n_checks++;
    if (beats !== 20) $display("FAIL fast_beat_count: got %0d want 20", beats);
    else n_pass++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; bpm = 9'd60; bpb = 4'd4; acc = 1'b0;
    rst2 = 1'b1; en2 = 1'b0; bpm2 = 9'd300; bpb2 = 4'd1; acc2 = 1'b0;
    tick(3);
    test_reset();
    test_start();
    test_clamp();
    test_accent_click();
    test_bpb_edges();
    test_live_change();
    test_disable();
    test_fast_click();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
